// File: rtl/instr_fetch_unit.sv
// Multicycle instruction fetch unit: fetches IR (and DI for LDI)
// over a req/ack memory port, advances PC, pulses fetch_done.
module instr_fetch_unit #(
    parameter int unsigned       DATA_W   = 13,
    parameter int unsigned       ADDR_W   = 13,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [2:0]        LDI_OP   = 3'b101
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_start,
    input  logic              flush,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_target,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] di,
    output logic [3:0]        opcode,
    output logic              ir_valid,
    output logic              fetch_done,
    output logic              busy,
    output logic [ADDR_W-1:0] pc
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_IR = 2'd1,
        REQ_DI = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   is_ldi;

    assign is_ldi   = (mem_rdata[DATA_W-1 -: 3] == LDI_OP);
    assign mem_addr = pc;
    assign opcode   = ir[DATA_W-1 -: 4];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush wins over a same-cycle ack
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (fetch_start) state_nxt = REQ_IR;
            end
            REQ_IR: begin
                if (flush)        state_nxt = IDLE;
                else if (mem_ack) state_nxt = is_ldi ? REQ_DI : DONE;
            end
            REQ_DI: begin
                if (flush)        state_nxt = IDLE;
                else if (mem_ack) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control outputs decoded from state only
    always_comb begin
        mem_req    = 1'b0;
        fetch_done = 1'b0;
        busy       = 1'b1;
        unique case (state)
            IDLE:    busy       = 1'b0;
            REQ_IR:  mem_req    = 1'b1;
            REQ_DI:  mem_req    = 1'b1;
            DONE:    fetch_done = 1'b1;
            default: busy       = 1'b1;
        endcase
    end

    // PC, IR, DI and IR-valid datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            ir       <= '0;
            di       <= '0;
            ir_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pc_load)             pc       <= pc_target;
                    if (flush || fetch_start) ir_valid <= 1'b0;
                end
                REQ_IR: begin
                    if (flush) begin
                        ir_valid <= 1'b0;
                    end else if (mem_ack) begin
                        ir       <= mem_rdata;
                        pc       <= pc + ADDR_W'(1);
                        ir_valid <= !is_ldi;
                    end
                end
                REQ_DI: begin
                    if (flush) begin
                        ir_valid <= 1'b0;
                    end else if (mem_ack) begin
                        di       <= mem_rdata;
                        pc       <= pc + ADDR_W'(1);
                        ir_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (flush) ir_valid <= 1'b0;
                end
                default: ir_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: table of fetch vectors
// plus hand sequences for jump-ignore, flush and async reset.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_start = 1'b0;
    logic        flush = 1'b0;
    logic        pc_load = 1'b0;
    logic [12:0] pc_target = '0;
    logic        mem_req;
    logic [12:0] mem_addr;
    logic [12:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [12:0] ir;
    logic [12:0] di;
    logic [3:0]  opcode;
    logic        ir_valid;
    logic        fetch_done;
    logic        busy;
    logic [12:0] pc;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_start(fetch_start),
        .flush      (flush),
        .pc_load    (pc_load),
        .pc_target  (pc_target),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .ir         (ir),
        .di         (di),
        .opcode     (opcode),
        .ir_valid   (ir_valid),
        .fetch_done (fetch_done),
        .busy       (busy),
        .pc         (pc)
    );

    always #5 clk = ~clk;

    // Memory model with programmable wait states
    logic [12:0] mem [0:8191];
    int          wait_n  = 0;
    int          wcnt    = 0;
    logic        auto_en = 1'b1;

    always @(negedge clk) begin
        if (auto_en) begin
            if (mem_req) begin
                if (wcnt >= wait_n) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr];
                    wcnt      = 0;
                end else begin
                    mem_ack = 1'b0;
                    wcnt    = wcnt + 1;
                end
            end else begin
                mem_ack = 1'b0;
                wcnt    = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [12:0] tgt;
        logic [12:0] w0;
        logic [12:0] w1;
        int          wt;
        logic [12:0] e_ir;
        logic [12:0] e_di;
        logic [12:0] e_pc;
        logic [3:0]  e_op;
        int          e_done;
    } vec_t;

    vec_t vecs [6];

    int   d_cyc;
    int   d_cnt;
    logic stable;
    logic vld_end;

    // Load+fetch at tgt; optionally try a pc_load to 0x55 at cycle inj
    task automatic run_fetch(input logic [12:0] tgt, input int wt,
                             input int inj, output int dc,
                             output int dn, output logic st,
                             output logic ve);
        logic [12:0] a1;
        a1 = tgt + 13'd1;
        dc = 0;
        dn = 0;
        st = 1'b1;
        wait_n = wt;
        @(negedge clk);
        pc_load     = 1'b1;
        pc_target   = tgt;
        fetch_start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                fetch_start = 1'b0;
                pc_load     = 1'b0;
            end
            if (k == inj) begin
                pc_load   = 1'b1;
                pc_target = 13'h0055;
            end
            if (k == inj + 1) pc_load = 1'b0;
            if (k <= wt + 1) begin
                if (!mem_req || mem_addr !== tgt) st = 1'b0;
            end else if (k <= 2 * wt + 2 && busy && !fetch_done) begin
                if (!mem_req || mem_addr !== a1) st = 1'b0;
            end
            if (fetch_done) begin
                dn++;
                if (dc == 0) dc = k;
            end
            if (!busy && k > 1) break;
        end
        pc_load = 1'b0;
        ve = ir_valid;
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = '0;
        vecs[0] = '{13'h0000, 13'h0A5A, 13'h0000, 0,
                    13'h0A5A, 13'h0000, 13'h0001, 4'h5, 2};
        vecs[1] = '{13'h0000, 13'h1400, 13'h00FF, 0,
                    13'h1400, 13'h00FF, 13'h0002, 4'hA, 3};
        vecs[2] = '{13'h0000, 13'h1400, 13'h00FF, 3,
                    13'h1400, 13'h00FF, 13'h0002, 4'hA, 9};
        vecs[3] = '{13'h1FFF, 13'h0123, 13'h1400, 0,
                    13'h0123, 13'h00FF, 13'h0000, 4'h0, 2};
        vecs[4] = '{13'h1FFE, 13'h1555, 13'h0123, 0,
                    13'h1555, 13'h0123, 13'h0000, 4'hA, 3};
        vecs[5] = '{13'h0010, 13'h0FFF, 13'h0000, 2,
                    13'h0FFF, 13'h0123, 13'h0011, 4'h7, 4};

        // Reset state
        #12;
        chk("rst_pc", pc, 0);
        chk("rst_ir", ir, 0);
        chk("rst_di", di, 0);
        chk("rst_ir_valid", ir_valid, 0);
        chk("rst_fetch_done", fetch_done, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_addr", mem_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven fetches
        for (int v = 0; v < 6; v++) begin
            logic [12:0] a;
            a = vecs[v].tgt;
            mem[a] = vecs[v].w0;
            a = a + 13'd1;
            if (vecs[v].w0[12:10] == 3'b101) mem[a] = vecs[v].w1;
            run_fetch(vecs[v].tgt, vecs[v].wt, 0, d_cyc, d_cnt,
                      stable, vld_end);
            chk($sformatf("v%0d_ir", v), ir, vecs[v].e_ir);
            chk($sformatf("v%0d_di", v), di, vecs[v].e_di);
            chk($sformatf("v%0d_pc", v), pc, vecs[v].e_pc);
            chk($sformatf("v%0d_opcode", v), opcode, vecs[v].e_op);
            chk($sformatf("v%0d_done_cycle", v), d_cyc, vecs[v].e_done);
            chk($sformatf("v%0d_done_count", v), d_cnt, 1);
            chk($sformatf("v%0d_req_stable", v), stable, 1);
            chk($sformatf("v%0d_ir_valid", v), vld_end, 1);
            chk($sformatf("v%0d_mem_req_idle", v), mem_req, 0);
        end

        // pc_load while in REQ_IR is ignored
        mem[13'h0020] = 13'h0111;
        run_fetch(13'h0020, 3, 2, d_cyc, d_cnt, stable, vld_end);
        chk("jmp_ign_pc", pc, 13'h0021);
        chk("jmp_ign_ir", ir, 13'h0111);
        chk("jmp_ign_done_cycle", d_cyc, 5);
        chk("jmp_ign_di", di, 13'h0123);
        @(negedge clk);
        chk("jmp_ign_pc_idle", pc, 13'h0021);

        // Flush in REQ_DI together with ack
        auto_en = 1'b0;
        mem_ack = 1'b0;
        @(negedge clk);
        pc_load     = 1'b1;
        pc_target   = 13'h0030;
        fetch_start = 1'b1;
        @(negedge clk);
        pc_load     = 1'b0;
        fetch_start = 1'b0;
        chk("fl_req_ir", mem_req, 1);
        chk("fl_ir_valid_clr", ir_valid, 0);
        mem_ack   = 1'b1;
        mem_rdata = 13'h1400;
        @(negedge clk);
        chk("fl_req_di", mem_req, 1);
        chk("fl_addr_di", mem_addr, 13'h0031);
        mem_ack   = 1'b1;
        mem_rdata = 13'h0ABC;
        flush     = 1'b1;
        @(negedge clk);
        flush   = 1'b0;
        mem_ack = 1'b0;
        chk("fl_busy", busy, 0);
        chk("fl_mem_req", mem_req, 0);
        chk("fl_fetch_done", fetch_done, 0);
        chk("fl_ir_valid", ir_valid, 0);
        chk("fl_di", di, 13'h0123);
        chk("fl_pc", pc, 13'h0031);
        chk("fl_ir", ir, 13'h1400);
        @(negedge clk);
        chk("fl_fetch_done_next", fetch_done, 0);

        // Asynchronous reset mid-fetch
        pc_load     = 1'b1;
        pc_target   = 13'h0005;
        fetch_start = 1'b1;
        @(negedge clk);
        pc_load     = 1'b0;
        fetch_start = 1'b0;
        @(negedge clk);
        chk("ar_pre_req", mem_req, 1);
        chk("ar_pre_pc", pc, 13'h0005);
        mem_ack   = 1'b1;
        mem_rdata = 13'h0777;
        #1;
        rst = 1'b1;
        #1;
        chk("ar_pc", pc, 0);
        chk("ar_mem_req", mem_req, 0);
        chk("ar_ir", ir, 0);
        chk("ar_busy", busy, 0);
        chk("ar_mem_addr", mem_addr, 0);
        @(negedge clk);
        mem_ack = 1'b0;
        rst     = 1'b0;
        @(negedge clk);
        chk("ar_post_pc", pc, 0);
        chk("ar_post_ir_valid", ir_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
